// File: rtl/mips_alu_if.sv
// EX-stage ALU bus: operation request in, result/branch/done out.
// master drives operations (D2E side), slave is the ALU.
interface mips_alu_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CTL_WIDTH  = 5
);
  logic                  in_valid;
  logic [CTL_WIDTH-1:0]  in_alu_ctl;
  logic [DATA_WIDTH-1:0] in_op1;
  logic [DATA_WIDTH-1:0] in_op2;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_result;
  logic                  out_branch_taken;
  logic                  done;

  modport master (
    output in_valid, in_alu_ctl, in_op1, in_op2,
    input  out_valid, out_result, out_branch_taken, done
  );

  modport slave (
    input  in_valid, in_alu_ctl, in_op1, in_op2,
    output out_valid, out_result, out_branch_taken, done
  );
endinterface

// File: rtl/mips_alu.sv
// MIPS32 EX-stage integer ALU: combinational result/branch outcome,
// plus architectural HI/LO and a sticky end-of-program flag.
module mips_alu #(
  parameter int DATA_WIDTH = 32,
  parameter int CTL_WIDTH  = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  mips_alu_if.slave   bus
);
  typedef enum logic [4:0] {
    OP_NOP,  OP_ADD,  OP_ADDU, OP_SUB,  OP_SUBU, OP_AND,  OP_OR,   OP_XOR,
    OP_NOR,  OP_SLT,  OP_SLTU, OP_SLL,  OP_SRL,  OP_SRA,  OP_LUI,  OP_MFHI,
    OP_MFLO, OP_MTHI, OP_MTLO, OP_MULT, OP_MULTU,OP_DIV,  OP_DIVU, OP_BA,
    OP_BEQ,  OP_BNE,  OP_BLEZ, OP_BGTZ, OP_BGEZ, OP_BLTZ, OP_DONE, OP_RSVD
  } alu_op_e;

  localparam int W = DATA_WIDTH;

  alu_op_e      op;
  logic [W-1:0] a, b, hi, lo, result;
  logic [4:0]   shamt;
  logic         taken, done_r;

  assign op    = alu_op_e'(bus.in_alu_ctl);
  assign a     = bus.in_op1;
  assign b     = bus.in_op2;
  assign shamt = b[4:0];

  // Low 64 bits of sign-extended operands give the signed product.
  logic [2*W-1:0] prod_s, prod_u;
  assign prod_s = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
  assign prod_u = {{W{1'b0}}, a} * {{W{1'b0}}, b};

  // One unsigned divider shared by DIV/DIVU; signed ops divide magnitudes
  // and fix signs afterwards, which also yields MIN/-1 -> MIN, rem 0.
  logic         is_sdiv, div_zero;
  logic [W-1:0] a_mag, b_mag, dvd, dvs, q_u, r_u, quo, rem;
  assign is_sdiv  = (op == OP_DIV);
  assign div_zero = (b == '0);
  assign a_mag    = a[W-1] ? -a : a;
  assign b_mag    = b[W-1] ? -b : b;
  assign dvd      = is_sdiv ? a_mag : a;
  assign dvs      = div_zero ? {{(W-1){1'b0}}, 1'b1} : (is_sdiv ? b_mag : b);
  assign q_u      = dvd / dvs;
  assign r_u      = dvd % dvs;

  always_comb begin
    quo = q_u;
    rem = r_u;
    if (div_zero) begin
      quo = '1;
      rem = a;
    end else if (is_sdiv) begin
      quo = (a[W-1] ^ b[W-1]) ? -q_u : q_u;
      rem = a[W-1] ? -r_u : r_u;
    end
  end

  always_comb begin
    result = '0;
    taken  = 1'b0;
    if (bus.in_valid) begin
      case (op)
        OP_ADD, OP_ADDU: result = a + b;
        OP_SUB, OP_SUBU: result = a - b;
        OP_AND:  result = a & b;
        OP_OR:   result = a | b;
        OP_XOR:  result = a ^ b;
        OP_NOR:  result = ~(a | b);
        OP_SLT:  result = {{(W-1){1'b0}}, $signed(a) < $signed(b)};
        OP_SLTU: result = {{(W-1){1'b0}}, a < b};
        OP_SLL:  result = a << shamt;
        OP_SRL:  result = a >> shamt;
        OP_SRA:  result = $unsigned($signed(a) >>> shamt);
        OP_LUI:  result = {b[15:0], 16'h0000};
        OP_MFHI: result = hi;
        OP_MFLO: result = lo;
        OP_BA:   taken  = 1'b1;
        OP_BEQ:  taken  = (a == b);
        OP_BNE:  taken  = (a != b);
        OP_BLEZ: taken  = a[W-1] || (a == '0);
        OP_BGTZ: taken  = !a[W-1] && (a != '0);
        OP_BGEZ: taken  = !a[W-1];
        OP_BLTZ: taken  = a[W-1];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi     <= '0;
      lo     <= '0;
      done_r <= 1'b0;
    end else if (bus.in_valid) begin
      case (op)
        OP_MTHI:  hi <= a;
        OP_MTLO:  lo <= a;
        OP_MULT:  {hi, lo} <= prod_s;
        OP_MULTU: {hi, lo} <= prod_u;
        OP_DIV, OP_DIVU: begin
          hi <= rem;
          lo <= quo;
        end
        OP_DONE:  done_r <= 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.out_valid        = bus.in_valid;
  assign bus.out_result       = result;
  assign bus.out_branch_taken = taken;
  assign bus.done             = done_r;
endmodule

// File: tb/tb_mips_alu.sv
// Directed bench for mips_alu: expectations queued at drive time,
// popped and compared when the outputs are sampled on the falling edge.
module tb_mips_alu;
  localparam logic [4:0] NOP = 0, ADD = 1, SUB = 3, AND_ = 5, OR_ = 6, XOR_ = 7,
    NOR_ = 8, SLT = 9, SLTU = 10, SLL = 11, SRL = 12, SRA = 13, LUI = 14,
    MFHI = 15, MFLO = 16, MTHI = 17, MTLO = 18, MULT = 19, MULTU = 20,
    DIV = 21, DIVU = 22, BA = 23, BEQ = 24, BNE = 25, BLEZ = 26, BGTZ = 27,
    BGEZ = 28, BLTZ = 29, DONE = 30, RSVD = 31;

  typedef struct {
    string       tag;
    logic        v;
    logic [31:0] res;
    logic        tk;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  mips_alu_if bus();
  mips_alu u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic v, input logic [4:0] ctl,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] er, input logic et);
    exp_t e;
    @(posedge clk);
    #1;
    bus.in_valid   = v;
    bus.in_alu_ctl = ctl;
    bus.in_op1     = a;
    bus.in_op2     = b;
    sb.push_back('{tag, v, er, et});
    @(negedge clk);
    if (sb.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".valid"}, {31'd0, bus.out_valid}, {31'd0, e.v});
      chk({e.tag, ".result"}, bus.out_result, e.res);
      chk({e.tag, ".taken"}, {31'd0, bus.out_branch_taken}, {31'd0, e.tk});
    end
  endtask

  initial begin
    bus.in_valid = 0; bus.in_alu_ctl = '0; bus.in_op1 = '0; bus.in_op2 = '0;

    // Reset state
    step("rst_mfhi", 1, MFHI, 0, 0, 32'h0, 0);
    step("rst_mflo", 1, MFLO, 0, 0, 32'h0, 0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    rst_n = 1'b1;

    // Arithmetic / logic
    step("add_wrap", 1, ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0);
    step("sub_neg",  1, SUB, 32'h0, 32'h1, 32'hFFFF_FFFF, 0);
    step("invalid",  0, ADD, 32'h3, 32'h4, 32'h0, 0);
    step("and",  1, AND_, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0);
    step("or",   1, OR_,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 0);
    step("xor",  1, XOR_, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 0);
    step("nor",  1, NOR_, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, 0);
    step("slt",  1, SLT,  32'hFFFF_FFFF, 32'h1, 32'h1, 0);
    step("sltu", 1, SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 0);
    step("sll",  1, SLL,  32'h1, 32'h21, 32'h2, 0);
    step("srl",  1, SRL,  32'h8000_0000, 32'h4, 32'h0800_0000, 0);
    step("sra",  1, SRA,  32'h8000_0000, 32'h24, 32'hF800_0000, 0);
    step("lui",  1, LUI,  32'h0, 32'hABCD_1234, 32'h1234_0000, 0);

    // HI/LO
    step("mult",     1, MULT,  32'hFFFF_FFFE, 32'h3, 32'h0, 0);
    step("mult_hi",  1, MFHI,  0, 0, 32'hFFFF_FFFF, 0);
    step("mult_lo",  1, MFLO,  0, 0, 32'hFFFF_FFFA, 0);
    step("multu",    1, MULTU, 32'hFFFF_FFFE, 32'h3, 32'h0, 0);
    step("multu_hi", 1, MFHI,  0, 0, 32'h0000_0002, 0);
    step("multu_lo", 1, MFLO,  0, 0, 32'hFFFF_FFFA, 0);
    step("div",      1, DIV,   32'hFFFF_FFF9, 32'h2, 32'h0, 0);
    step("div_lo",   1, MFLO,  0, 0, 32'hFFFF_FFFD, 0);
    step("div_hi",   1, MFHI,  0, 0, 32'hFFFF_FFFF, 0);
    step("divu0",    1, DIVU,  32'h5, 32'h0, 32'h0, 0);
    step("divu0_lo", 1, MFLO,  0, 0, 32'hFFFF_FFFF, 0);
    step("divu0_hi", 1, MFHI,  0, 0, 32'h5, 0);
    step("divmin",   1, DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0);
    step("divmin_lo",1, MFLO,  0, 0, 32'h8000_0000, 0);
    step("divmin_hi",1, MFHI,  0, 0, 32'h0, 0);
    step("divu",     1, DIVU,  32'd100, 32'd7, 32'h0, 0);
    step("divu_lo",  1, MFLO,  0, 0, 32'd14, 0);
    step("divu_hi",  1, MFHI,  0, 0, 32'd2, 0);
    step("mthi",     1, MTHI,  32'h11, 0, 32'h0, 0);
    step("mthi_rd",  1, MFHI,  0, 0, 32'h11, 0);
    step("mtlo",     1, MTLO,  32'h22, 0, 32'h0, 0);
    step("mtlo_rd",  1, MFLO,  0, 0, 32'h22, 0);
    step("mthi_inv", 0, MTHI,  32'h99, 0, 32'h0, 0);
    step("hi_kept",  1, MFHI,  0, 0, 32'h11, 0);

    // Branches
    step("ba",      1, BA,   32'h0, 32'h0, 32'h0, 1);
    step("beq",     1, BEQ,  32'h5, 32'h5, 32'h0, 1);
    step("bne",     1, BNE,  32'h5, 32'h5, 32'h0, 0);
    step("blez0",   1, BLEZ, 32'h0, 32'h0, 32'h0, 1);
    step("bgtz0",   1, BGTZ, 32'h0, 32'h0, 32'h0, 0);
    step("bgtz1",   1, BGTZ, 32'h1, 32'h0, 32'h0, 1);
    step("bgez_n",  1, BGEZ, 32'hFFFF_FFFF, 32'h0, 32'h0, 0);
    step("bltz",    1, BLTZ, 32'h8000_0000, 32'h0, 32'h0, 1);
    step("beq_inv", 0, BEQ,  32'h5, 32'h5, 32'h0, 0);
    step("rsvd",    1, RSVD, 32'h5, 32'h5, 32'h0, 0);

    // Sticky done
    step("done_inv", 0, DONE, 0, 0, 32'h0, 0);
    step("nop_a",    1, NOP,  0, 0, 32'h0, 0);
    chk("done_stays0", {31'd0, bus.done}, 32'd0);
    step("done",     1, DONE, 0, 0, 32'h0, 0);
    chk("done_same_cycle", {31'd0, bus.done}, 32'd0);
    step("nop_b",    1, NOP,  0, 0, 32'h0, 0);
    chk("done_set", {31'd0, bus.done}, 32'd1);
    step("nop_c",    0, NOP,  0, 0, 32'h0, 0);
    chk("done_sticky", {31'd0, bus.done}, 32'd1);

    // Asynchronous reset mid-cycle
    step("mult2",    1, MULT, 32'h1234_5678, 32'h10, 32'h0, 0);
    step("mult2_hi", 1, MFHI, 0, 0, 32'h1, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_done", {31'd0, bus.done}, 32'd0);
    chk("arst_hi", bus.out_result, 32'h0);
    bus.in_alu_ctl = MFLO;
    #1;
    chk("arst_lo", bus.out_result, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step("post_rst", 1, ADD, 32'h2, 32'h3, 32'h5, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
